gf180mcu_fd_sc_mcu7t5v0__bufz_arb: RTL
======================================

Name: gf180mcu_fd_sc_mcu7t5v0__bufz_arb

Overview:
Upstream control stage for a group of tri-state bus drivers: it decides which of NREQ agents owns a shared tri-state bus and produces the per-driver enable (EN) and data (I) inputs for the bufz cells.
- Guarantees at most one EN high at any time.
- Inserts turnaround cycles with all EN low between owners.
- Registers the owner's data so the bus sees clean, clocked values.

Parameters:
NREQ, 4, number of requesting agents / bufz drivers (2..16)
DW, 8, data width per driver
TURN, 1, idle cycles with all EN low after a release, before the next arbitration (0..15)
MAXHOLD, 16, maximum consecutive cycles one owner may drive; used only with the optional feature (1..255)

Ports:
CLK  input  1  rising-edge clock
RN  input  1  synchronous active-low reset
REQ  input  NREQ  level request per agent; bit k high = agent k wants the bus
DIN  input  NREQ*DW  data per agent; slice k = DIN[k*DW +: DW]
GNT  output  NREQ  one-hot grant, or all zero
EN  output  NREQ  enable to bufz cell k; equals GNT
I  output  NREQ*DW  registered data to bufz cell k; non-owner slices are zero
BUSY  output  1  high in DRIVE or TURN state

Behaviour:
- Interface (already decided): one clock CLK; reset RN is synchronous and active-low. All state updates on the CLK rising edge only; no asynchronous paths.
- Reset: on any edge with RN=0:
  - state=IDLE; GNT=0, EN=0, I=0, BUSY=0; priority pointer ptr=0; counters=0.
  - This applies mid-DRIVE too: EN drops at that edge.
- All outputs are registered.
- States are IDLE, DRIVE and TURN.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise the winner w is the first set REQ bit searching ptr, ptr+1, …, wrapping modulo NREQ.
  - Next edge: state=DRIVE, GNT[w]=EN[w]=1, I slice w = DIN slice w, hold counter=1.
  - Latency: REQ high sampled at edge k gives EN high from edge k.
- DRIVE (owner w):
  - Each edge: I slice w <= DIN slice w (one-cycle data latency). Other slices stay 0.
  - Release when REQ[w]==0 is sampled. With the optional feature, also release when hold counter==MAXHOLD.
  - On release edge: GNT=EN=0, I=0, ptr=(w+1) mod NREQ.
  - Next state is TURN with turn counter=TURN, or IDLE if TURN==0.
  - Requests from other agents during DRIVE are ignored; they stay pending because REQ is level.
- TURN:
  - Counter decrements each edge; move to IDLE on the edge where the counter reaches 1.
  - All EN stay low throughout.
- Minimum gap between one EN falling and any EN rising is TURN+1 cycles; the +1 is the IDLE arbitration cycle.
- Owner keeping REQ high with the feature disabled: it holds the bus indefinitely.
- Owner releasing and re-requesting: the pointer has moved past it, so another pending agent wins first (fairness).
- Invariant: popcount(EN) ≤ 1 every cycle, including across reset.

Optional Feature:
Macro: GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN
- Defined:
  - DRIVE forcibly releases after exactly MAXHOLD cycles with EN high, even if REQ[w] stays high.
  - A released agent whose REQ is still high re-competes under round-robin after TURN.
  - The 8-bit hold counter is present.
- Not defined:
  - The hold counter and MAXHOLD comparison are absent.
  - Release happens only when REQ[w] drops; MAXHOLD is ignored.

Test Plan:
1. RN=0 for 2 cycles with REQ=4'b1111 → GNT=EN=0, I=0, BUSY=0. Release RN with REQ=4'b0010 and DIN slice1=8'hA5 → one edge later EN=4'b0010 and I slice1=8'hA5; all other I slices 00.
2. REQ=4'b1111 held, each owner drops REQ 3 cycles after its grant, then re-raises. TURN=1 → grant order 0,1,2,3,0, with exactly 2 all-zero EN cycles between consecutive grants.
3. Owner 2 driving, DIN slice2 sequence 01,02,03 on consecutive cycles → I slice2 shows 01,02,03, each delayed one cycle. Popcount(EN)≤1 is checked every cycle.
4. RN=0 asserted mid-DRIVE (owner 3) → EN=0 at that edge. After release, REQ=4'b1000 is granted again from ptr=0 search; the winner is 3 because it is the only request.
5. With GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN and MAXHOLD=16, REQ[0] held high continuously and REQ[1] high → EN[0] high for exactly 16 cycles, then TURN, then EN[1] granted. Without the macro, EN[0] stays high for 100+ cycles.
6. TURN=0, owner 1 drops REQ while REQ[2] high → EN all zero for exactly 1 cycle, then EN=4'b0100.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv
// Round-robin owner arbiter feeding a group of bufz tri-state drivers: one-hot EN, registered data, turnaround gap.
// Optional forced release after MAXHOLD cycles: define GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*DW-1:0] DIN,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   EN,
  output logic [NREQ*DW-1:0] I,
  output logic              BUSY
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

  if (NREQ < 2 || NREQ > 16 || TURN < 0 || TURN > 15 || MAXHOLD < 1 || MAXHOLD > 255) begin : g_param_range
    $error("bufz_arb: parameter out of range");
  end

  state_t              state, state_n;
  logic [NREQ-1:0]     gnt_p0, gnt_n;
  logic [NREQ*DW-1:0]  data_p0, data_n;
  logic                busy_p0, busy_n;
  logic [PW-1:0]       ptr, ptr_n;
  logic [PW-1:0]       owner, owner_n;
  logic [PW-1:0]       win;
  logic                found;
  logic [3:0]          tcnt, tcnt_n;
  logic                release_bus;
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN
  logic [7:0]          hold, hold_n;
`endif

  // Round-robin search: first set request starting at ptr, wrapping modulo NREQ.
  always_comb begin
    int sum;
    logic [PW-1:0] idx;
    found = 1'b0;
    win   = '0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = PW'(sum);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt_p0;
    data_n      = data_p0;
    ptr_n       = ptr;
    owner_n     = owner;
    tcnt_n      = tcnt;
    release_bus = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN
    hold_n      = hold;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          state_n                = S_DRIVE;
          owner_n                = win;
          gnt_n                  = '0;
          gnt_n[win]             = 1'b1;
          data_n                 = '0;
          data_n[win*DW +: DW]   = DIN[win*DW +: DW];
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN
          hold_n                 = 8'd1;
`endif
        end
      end
      S_DRIVE: begin
        release_bus = !REQ[owner];
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN
        release_bus = release_bus || (hold == 8'(MAXHOLD));
        hold_n      = hold + 8'd1;
`endif
        if (release_bus) begin
          gnt_n  = '0;
          data_n = '0;
          ptr_n  = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          if (TURN == 0) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_TURN;
            tcnt_n  = 4'(TURN);
          end
        end else begin
          data_n[owner*DW +: DW] = DIN[owner*DW +: DW];
        end
      end
      S_TURN: begin
        if (tcnt <= 4'd1) begin
          state_n = S_IDLE;
          tcnt_n  = '0;
        end else begin
          tcnt_n  = tcnt - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // Registered outputs: reset clears data too so the bus never sees stale values.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state   <= S_IDLE;
      gnt_p0  <= '0;
      data_p0 <= '0;
      busy_p0 <= 1'b0;
      ptr     <= '0;
      owner   <= '0;
      tcnt    <= '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN
      hold    <= '0;
`endif
    end else begin
      state   <= state_n;
      gnt_p0  <= gnt_n;
      data_p0 <= data_n;
      busy_p0 <= busy_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      tcnt    <= tcnt_n;
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_ARB_TIMEOUT_EN
      hold    <= hold_n;
`endif
    end
  end

  assign GNT  = gnt_p0;
  assign EN   = gnt_p0;
  assign I    = data_p0;
  assign BUSY = busy_p0;

endmodule
